// File: rtl/ahb_bridge_arbiter_pkg.sv
// Shared types and constants for the AHB-to-APB bridge round-robin arbiter.
// Optional watchdog is enabled with the ARB_TIMEOUT_EN macro.
package ahb_bridge_arb_pkg;

    localparam int ADDR_W_DEF  = 7;
    localparam int DATA_W_DEF  = 32;

    // Address split seen by the bridge: [6:5] picks the APB slave, [4:0] is PADDR.
    localparam int SLV_SEL_MSB = 6;
    localparam int SLV_SEL_LSB = 5;
    localparam int PADDR_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// Requester-side and bridge-side signal bundle for ahb_bridge_arbiter.
// master = arbiter view, slave = requesters plus bridge view.
interface ahb_bridge_arbiter_if
    import ahb_bridge_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      req_err;
    logic [DATA_W-1:0]         req_rdata;

    logic                      HSEL;
    logic [ADDR_W-1:0]         HADDR;
    logic                      HWRITE;
    logic                      HREADY;
    logic [DATA_W-1:0]         HWDATA;
    logic                      HREADYOUT;
    logic [DATA_W-1:0]         HRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, HREADYOUT, HRDATA,
        output req_ack, req_err, req_rdata, HSEL, HADDR, HWRITE, HREADY, HWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, HREADYOUT, HRDATA,
        input  req_ack, req_err, req_rdata, HSEL, HADDR, HWRITE, HREADY, HWDATA
    );

endinterface

// File: rtl/ahb_bridge_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after the pointer,
// wrapping modulo NUM_REQ; returns one-hot grant and encoded index.
module rr_pick
    import ahb_bridge_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o
);

    int j;

    // Scan from the farthest offset down so the closest valid requester wins last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (valid_i[PTR_W'(j)]) begin
                grant_o              = '0;
                grant_o[PTR_W'(j)]   = 1'b1;
                idx_o                = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin sequencer sharing one AHB-to-APB bridge port between NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to abort stalled data phases after TIMEOUT_CYCLES with req_err.
module ahb_bridge_arbiter
    import ahb_bridge_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   HCLK,
    input  logic                   RESET,
    ahb_bridge_arbiter_if.master   bus
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                first_q, first_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  pick_grant;
    logic [PTR_W-1:0]    pick_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            first_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            first_q <= first_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        first_d       = first_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_d         = err_q;
`endif
        bus.HSEL      = 1'b0;
        bus.HADDR     = '0;
        bus.HWRITE    = 1'b0;
        bus.HREADY    = 1'b1;
        bus.HWDATA    = '0;
        bus.req_ack   = '0;
        bus.req_rdata = '0;
        bus.req_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Requester inputs are sampled only here; later changes never reach the bus.
                if (|pick_grant) begin
                    idx_d   = pick_idx;
                    write_d = bus.req_write[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus.HSEL   = 1'b1;
                bus.HADDR  = addr_q;
                bus.HWRITE = write_q;
                first_d    = 1'b1;
                rdata_d    = '0;
`ifdef ARB_TIMEOUT_EN
                cnt_d      = '0;
                err_d      = 1'b0;
`endif
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                bus.HADDR  = addr_q;
                bus.HWRITE = write_q;
                bus.HWDATA = write_q ? wdata_q : '0;
                bus.HREADY = bus.HREADYOUT;
                first_d    = 1'b0;
                // The bridge's HREADYOUT in the first data cycle still reflects its setup phase.
                if (!first_q && bus.HREADYOUT) begin
                    rdata_d = write_q ? '0 : bus.HRDATA;
                    state_d = ST_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                bus.req_ack[idx_q] = 1'b1;
                bus.req_rdata      = rdata_q;
`ifdef ARB_TIMEOUT_EN
                bus.req_err        = err_q;
`endif
                ptr_d   = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed scoreboard bench for ahb_bridge_arbiter: stimulus pushes expected bus and
// response entries, a monitor pops and compares them as the DUT presents them.
module tb_ahb_bridge_arbiter;

    localparam int NR = 4;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } addr_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    addr_t addr_q[$];
    resp_t resp_q[$];
    addr_t cur;
    bit    in_data = 1'b0;

    ahb_bridge_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ahb_bridge_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK  (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push(input int i, input logic wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                                 input logic err, input int c, input bit with_resp);
        addr_t ae;
        resp_t re;
        ae.addr  = a;
        ae.wr    = wr;
        ae.wdata = wd;
        addr_q.push_back(ae);
        if (with_resp) begin
            re.idx   = i;
            re.rdata = wr ? '0 : rd;
            re.err   = err;
            re.cyc   = c;
            resp_q.push_back(re);
        end
    endfunction

    task automatic issue(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.req_write[i]          = wr;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = wd;
        bus.req_valid[i]          = 1'b1;
    endtask

    task automatic wait_acks(input logic [NR-1:0] mask, input int budget);
        logic [NR-1:0] pend;
        int n;
        pend = mask;
        n = 0;
        while (pend != '0 && n < budget) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ack[i] && pend[i]) begin
                    bus.req_valid[i] = 1'b0;
                    pend[i] = 1'b0;
                end
            end
        end
        chk("ack_wait_budget", 32'(pend), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_HSEL"},   32'(bus.HSEL),      32'd0);
        chk({tag, "_HADDR"},  32'(bus.HADDR),     32'd0);
        chk({tag, "_HWRITE"}, 32'(bus.HWRITE),    32'd0);
        chk({tag, "_HREADY"}, 32'(bus.HREADY),    32'd1);
        chk({tag, "_HWDATA"}, bus.HWDATA,         32'd0);
        chk({tag, "_ack"},    32'(bus.req_ack),   32'd0);
        chk({tag, "_rdata"},  bus.req_rdata,      32'd0);
        chk({tag, "_err"},    32'(bus.req_err),   32'd0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        resp_t e;
        #1;
        if (rst) begin
            in_data = 1'b0;
        end else if (bus.req_ack != '0) begin
            in_data = 1'b0;
            if (resp_q.size() == 0) begin
                chk("unexpected_ack", 32'(bus.req_ack), 32'd0);
            end else begin
                e = resp_q.pop_front();
                chk("ack_onehot", 32'(bus.req_ack), 32'd1 << e.idx);
                chk("ack_rdata",  bus.req_rdata, e.rdata);
                chk("ack_err",    32'(bus.req_err), 32'(e.err));
                chk("ack_hsel_low", 32'(bus.HSEL), 32'd0);
                if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
            end
        end else if (bus.HSEL) begin
            if (addr_q.size() == 0) begin
                chk("unexpected_hsel", 32'(bus.HSEL), 32'd0);
            end else begin
                cur = addr_q.pop_front();
                chk("addr_HADDR",  32'(bus.HADDR),  32'(cur.addr));
                chk("addr_HWRITE", 32'(bus.HWRITE), 32'(cur.wr));
                chk("addr_HREADY", 32'(bus.HREADY), 32'd1);
                in_data = 1'b1;
            end
        end else if (in_data) begin
            chk("data_HADDR",  32'(bus.HADDR),  32'(cur.addr));
            chk("data_HWRITE", 32'(bus.HWRITE), 32'(cur.wr));
            chk("data_HWDATA", bus.HWDATA, cur.wr ? cur.wdata : 32'd0);
            chk("data_HREADY", 32'(bus.HREADY), 32'(bus.HREADYOUT));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        int p;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.HREADYOUT = 1'b1;
        bus.HRDATA    = '0;

        // Reset state
        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk); rst = 1'b0;

        // Single write from req0 to slave 2
        @(negedge clk); p = cyc;
        chk("slave_sel_45", 32'(7'h45 >> 5), 32'd2);
        issue(0, 1'b1, 7'h45, 32'hDEADBEEF);
        push(0, 1'b1, 7'h45, 32'hDEADBEEF, '0, 1'b0, p + 4, 1'b1);
        wait_acks(4'b0001, 20);

        // Read from req2
        @(negedge clk); p = cyc;
        bus.HRDATA = 32'h12345678;
        issue(2, 1'b0, 7'h13, '0);
        push(2, 1'b0, 7'h13, '0, 32'h12345678, 1'b0, p + 4, 1'b1);
        wait_acks(4'b0100, 20);

        // All four from reset: grants 0,1,2,3 then 1,3
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.HRDATA = 32'hCAFE0001;
        issue(0, 1'b1, 7'h01, 32'h11111111);
        issue(1, 1'b0, 7'h22, '0);
        issue(2, 1'b1, 7'h43, 32'h33333333);
        issue(3, 1'b0, 7'h64, '0);
        push(0, 1'b1, 7'h01, 32'h11111111, '0, 1'b0, -1, 1'b1);
        push(1, 1'b0, 7'h22, '0, 32'hCAFE0001, 1'b0, -1, 1'b1);
        push(2, 1'b1, 7'h43, 32'h33333333, '0, 1'b0, -1, 1'b1);
        push(3, 1'b0, 7'h64, '0, 32'hCAFE0001, 1'b0, -1, 1'b1);
        wait_acks(4'b1111, 60);
        @(negedge clk);
        issue(3, 1'b0, 7'h75, '0);
        issue(1, 1'b1, 7'h2C, 32'h55AA55AA);
        push(1, 1'b1, 7'h2C, 32'h55AA55AA, '0, 1'b0, -1, 1'b1);
        push(3, 1'b0, 7'h75, '0, 32'hCAFE0001, 1'b0, -1, 1'b1);
        wait_acks(4'b1010, 40);

        // Stall: HREADYOUT low for the data phase, ack one cycle after it rises
        @(negedge clk); p = cyc;
        bus.HREADYOUT = 1'b0;
        issue(0, 1'b1, 7'h2A, 32'hA5A5A5A5);
        push(0, 1'b1, 7'h2A, 32'hA5A5A5A5, '0, 1'b0, p + 7, 1'b1);
        repeat (5) begin
            @(negedge clk);
            bus.req_addr[0 +: AW]  = 7'h7F;
            bus.req_wdata[0 +: DW] = 32'hFFFFFFFF;
        end
        @(negedge clk);
        chk("stall_no_early_ack", 32'(bus.req_ack), 32'd0);
        bus.HREADYOUT = 1'b1;
        wait_acks(4'b0001, 10);

        // Reset asserted during DATA
        @(negedge clk); p = cyc;
        bus.HREADYOUT = 1'b0;
        issue(0, 1'b0, 7'h07, '0);
        push(0, 1'b0, 7'h07, '0, '0, 1'b0, -1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        check_reset_outputs("rst_in_data");
        @(negedge clk); rst = 1'b0; bus.HREADYOUT = 1'b1;
        @(negedge clk); p = cyc;
        issue(0, 1'b1, 7'h60, 32'h0BADF00D);
        push(0, 1'b1, 7'h60, 32'h0BADF00D, '0, 1'b0, p + 4, 1'b1);
        wait_acks(4'b0001, 20);

        // Bridge stuck: timeout abort when enabled, otherwise no ack
        @(negedge clk); p = cyc;
        bus.HREADYOUT = 1'b0;
        bus.HRDATA    = 32'h99999999;
        issue(1, 1'b0, 7'h31, '0);
`ifdef ARB_TIMEOUT_EN
        push(1, 1'b0, 7'h31, '0, '0, 1'b1, p + 2 + TO, 1'b1);
        wait_acks(4'b0010, 30);
`else
        push(1, 1'b0, 7'h31, '0, '0, 1'b0, -1, 1'b0);
        repeat (30) @(negedge clk);
        chk("stuck_still_pending", 32'(bus.req_valid), 32'b0010);
`endif
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        bus.HREADYOUT = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("addr_q_empty", addr_q.size(), 32'd0);
        chk("resp_q_empty", resp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_bridge_arbiter.md
Name: ahb_bridge_arbiter

Overview:
Round-robin arbiter/sequencer that shares the single AHB-to-APB bridge slave port between NUM_REQ local requesters.
- Accepts one single-beat read or write request per requester and drives the bridge's AHB-side signals (HSEL/HADDR/HWRITE/HREADY/HWDATA).
- Waits on the bridge's HREADYOUT and returns read data plus a one-cycle ack to the granted requester.
- Sits between the SoC's local masters and the bridge; the bridge itself is unchanged.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 7, AHB address width; [6:5] = APB slave select, [4:0] = PADDR
DATA_W, 32, data width
TIMEOUT_CYCLES, 64, watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
HCLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held high until matching ack
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse
req_err  out  1  error flag, valid with req_ack
req_rdata  out  DATA_W  read data, valid in the req_ack cycle
HSEL  out  1  bridge select
HADDR  out  ADDR_W  bridge address
HWRITE  out  1  bridge direction
HREADY  out  1  transfer-ready into bridge
HWDATA  out  DATA_W  bridge write data (data phase)
HREADYOUT  in  1  bridge ready
HRDATA  in  DATA_W  bridge read data

Behaviour:
- Reset (async, any state): state = IDLE, rr pointer = 0, all outputs 0 except HREADY = 1.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any req_valid, pick the winner: first requester with req_valid at or after the pointer, wrapping modulo NUM_REQ.
  - Latch the winner's index, write, addr and wdata; go to ADDR.
  - Otherwise remain in IDLE.
- ADDR (exactly 1 cycle): HSEL = 1; HADDR/HWRITE from latch; HREADY = 1; go to DATA.
- DATA:
  - HSEL = 0; HADDR/HWRITE hold; HWDATA = latched wdata for writes, 0 for reads; HREADY = HREADYOUT.
  - The first DATA cycle ignores HREADYOUT.
  - From the second DATA cycle on, HREADYOUT = 1 captures HRDATA (reads only) and moves to RESP.
- RESP (1 cycle): req_ack[idx] = 1, req_rdata valid (0 for writes), req_err = 0; pointer = idx + 1 mod NUM_REQ; go to IDLE.
- Latency: minimum 4 cycles from req_valid sampled in IDLE to ack; at least one IDLE cycle separates transfers.
- Only latched values drive the bus; requester changes after grant are ignored.
- A requester dropping req_valid while granted still receives its ack.
- Simultaneous requests: exactly one grant per transfer; pointer advance guarantees no starvation (worst-case wait = NUM_REQ-1 transfers).
- Requester that re-asserts req_valid in the ack cycle is not regranted ahead of higher-priority pending requesters.
- req_ack is never asserted outside RESP; at most one bit is set.

Optional Feature:
ARB_TIMEOUT_EN
- With the macro defined:
  - A counter runs in DATA, cleared on entry.
  - If it reaches TIMEOUT_CYCLES with HREADYOUT still 0, go to RESP with req_err = 1 and req_rdata = 0.
  - HSEL stays 0 during the abort.
- Without the macro: no counter; DATA waits indefinitely; req_err is tied to 0.

Decomposition:
- Package ahb_bridge_arb_pkg: FSM state enum; ADDR_W/DATA_W defaults; constants SLV_SEL_MSB = 6, SLV_SEL_LSB = 5, PADDR_W = 5.
- Sub-module rr_pick: combinational one-hot winner from req_valid and pointer, plus encoded index.

Test Plan:
- Single write: req0 addr 7'h45, wdata 32'hDEADBEEF -> HSEL high 1 cycle with HADDR 7'h45, HWRITE 1; HWDATA 32'hDEADBEEF next cycle; req_ack = 4'b0001 after HREADYOUT returns; bridge PSEL targets slave 2.
- Read: req2 addr 7'h13, slave returns 32'h12345678 -> req_ack = 4'b0100 with req_rdata 32'h12345678.
- All four requesters assert together from reset -> grant order 0,1,2,3; then with only req1 and req3 pending, order is 1,3.
- Bridge holds HREADYOUT low 5 cycles -> HREADY follows it; ack arrives exactly 1 cycle after HREADYOUT rises; latched HADDR/HWDATA stable throughout.
- RESET asserted in DATA -> next edge all outputs at reset values, no ack; after release, a new req0 starts cleanly.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, HREADYOUT stuck 0 -> req_ack with req_err = 1 after 8 DATA cycles; same test without macro -> no ack.
